// File: rtl/somador_serial_completo.sv
// rtl/somador_serial_completo.sv - bit-serial full adder, LSB first, one bit per clock
module somador_serial_completo #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             cout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   sh_a;
   logic [WIDTH-1:0]   sh_b;
   logic [WIDTH-1:0]   sum_q;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt;
   logic               s_bit;
   logic               carry_next;
   logic               last_bit;

   // single full-adder cell working on the current LSBs and the stored carry
   always_comb begin
      s_bit      = sh_a[0] ^ sh_b[0] ^ carry_q;
      carry_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry_q) | (sh_b[0] & carry_q);
      last_bit   = (cnt == CNT_W'(WIDTH - 1));
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; start only matters in IDLE, so a busy request is dropped silently
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN:  if (last_bit) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // operand capture, serial shifting and the final result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a    <= '0;
         sh_b    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         S       <= '0;
         cout    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  sh_a    <= A;
                  sh_b    <= B;
                  carry_q <= cin;
                  cnt     <= '0;
               end
            end
            RUN: begin
               sh_a    <= sh_a >> 1;
               sh_b    <= sh_b >> 1;
               carry_q <= carry_next;
               sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
               cnt     <= cnt + CNT_W'(1);
               // S/cout only ever see the complete word
               if (last_bit) begin
                  S    <= {s_bit, sum_q[WIDTH-1:1]};
                  cout <= carry_next;
               end
            end
            default: ;
         endcase
      end
   end

   // status outputs decoded from the registered state only
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

endmodule

// File: tb/tb_somador_serial_completo.sv
// tb/tb_somador_serial_completo.sv - self-checking bench for somador_serial_completo
module tb_somador_serial_completo;

   logic       clk;
   logic       rst_n;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, s8;
   logic       start4, cin4, busy4, done4, cout4;
   logic [3:0] a4, b4, s4;

   int n_cmp;
   int n_err;

   logic [7:0] prev_s8;
   logic       prev_c8;
   logic [3:0] prev_s4;
   logic       prev_c4;

   somador_serial_completo #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .cin(cin8),
      .busy(busy8), .done(done8), .S(s8), .cout(cout8)
   );

   somador_serial_completo #(.WIDTH(4), .CNT_W(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .cin(cin4),
      .busy(busy4), .done(done4), .S(s4), .cout(cout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // caller is just past a negedge with dut8 idle; returns at the negedge where done is seen
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      output logic [8:0] res, output int lat);
      logic held;
      held   = 1'b1;
      a8     = a;
      b8     = b;
      cin8   = ci;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      cin8   = 1'($urandom);
      lat    = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done8) break;
         if (s8 !== prev_s8 || cout8 !== prev_c8 || busy8 !== 1'b1) held = 1'b0;
      end
      check("op8_hold_busy", 32'(held), 32'd1);
      res     = {cout8, s8};
      prev_s8 = s8;
      prev_c8 = cout8;
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      output logic [4:0] res, output int lat);
      a4     = a;
      b4     = b;
      cin4   = ci;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      a4     = 4'($urandom);
      b4     = 4'($urandom);
      lat    = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done4) break;
      end
      res     = {cout4, s4};
      prev_s4 = s4;
      prev_c4 = cout4;
   endtask

   initial begin
      logic [8:0] r9;
      logic [4:0] r5;
      int         lat;
      logic [7:0] ha[0:20];
      logic [7:0] hb[0:20];
      logic       hc[0:20];
      logic       bz[0:20];
      logic [8:0] dres[0:1];
      int         dedge[0:1];
      int         ndone;
      int         drops;
      int         acc2;
      int         seen_done;
      time        t_done;
      time        t_prev;

      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      prev_s8 = '0; prev_c8 = 1'b0; prev_s4 = '0; prev_c4 = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_sum8", 32'({cout8, s8}), 32'd0);
      check("rst_sum4", 32'({busy4, done4, cout4, s4}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed vectors
      op8(8'h05, 8'h03, 1'b0, r9, lat);
      check("lat_05_03", 32'(lat), 32'd8);
      check("sum_05_03", 32'(r9), 32'h008);
      @(negedge clk);
      check("done_one_cycle", 32'({done8, busy8}), 32'd0);
      op8(8'hFF, 8'h01, 1'b0, r9, lat);
      check("sum_FF_01", 32'(r9), 32'h100);
      @(negedge clk);
      op8(8'hFF, 8'hFF, 1'b1, r9, lat);
      check("sum_FF_FF_1", 32'(r9), 32'h1FF);
      @(negedge clk);
      op8(8'h00, 8'h00, 1'b1, r9, lat);
      check("sum_00_00_1", 32'(r9), 32'h001);
      @(negedge clk);
      op8(8'h80, 8'h80, 1'b0, r9, lat);
      check("sum_80_80", 32'(r9), 32'h100);
      @(negedge clk);
      op8(8'hAA, 8'h55, 1'b0, r9, lat);
      check("sum_AA_55", 32'(r9), 32'h0FF);
      @(negedge clk);

      // start held high with operands changing every cycle
      ndone = 0;
      for (int e = 1; e <= 20; e++) begin
         ha[e]  = 8'(e * 13 + 5);
         hb[e]  = 8'(e * 29 + 1);
         hc[e]  = 1'(e);
         a8     = ha[e];
         b8     = hb[e];
         cin8   = hc[e];
         start8 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bz[e] = busy8;
         if (done8 && ndone < 2) begin
            dres[ndone]  = {cout8, s8};
            dedge[ndone] = e;
            ndone++;
         end
      end
      start8 = 1'b0;
      drops = 0;
      for (int e = 1; e <= 9; e++) if (!bz[e]) drops++;
      check("held_busy_drops", 32'(drops), 32'd0);
      acc2 = 0;
      for (int e = 2; e <= 20; e++) if (bz[e] && !bz[e-1] && acc2 == 0) acc2 = e;
      check("held_second_accept", 32'(acc2), 32'd11);
      check("held_done_count", 32'(ndone), 32'd2);
      check("held_done_edge0", 32'(dedge[0]), 32'd9);
      check("held_sum0", 32'(dres[0]), 32'({1'b0, ha[1]} + {1'b0, hb[1]} + 9'(hc[1])));
      check("held_sum1", 32'(dres[1]), 32'({1'b0, ha[11]} + {1'b0, hb[11]} + 9'(hc[11])));
      prev_s8 = s8;
      prev_c8 = cout8;
      @(negedge clk);

      // asynchronous reset in the middle of a run
      a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrun_rst_busy", 32'(busy8), 32'd0);
      check("midrun_rst_sum", 32'({cout8, s8}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      prev_s8 = '0; prev_c8 = 1'b0; prev_s4 = '0; prev_c4 = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 || busy8) seen_done++;
      end
      check("midrun_rst_quiet", 32'(seen_done), 32'd0);
      op8(8'h5A, 8'h33, 1'b1, r9, lat);
      check("after_rst_sum", 32'(r9), 32'h08E);
      @(negedge clk);

      // back-to-back: restart on the first idle cycle after each done
      t_prev = 0;
      for (int i = 0; i < 3; i++) begin
         op8(8'(i * 40 + 7), 8'(i * 90 + 200), 1'(i), r9, lat);
         t_done = $time;
         check("b2b_sum", 32'(r9), 32'({1'b0, 8'(i * 40 + 7)} + {1'b0, 8'(i * 90 + 200)} + 9'(i % 2)));
         if (i > 0) check("b2b_period", 32'((t_done - t_prev) / 10), 32'd10);
         t_prev = t_done;
         @(negedge clk);
      end

      // random vectors against the arithmetic model
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         op8(ra, rb, rc, r9, lat);
         check("rand8", 32'(r9), 32'({1'b0, ra} + {1'b0, rb} + 9'(rc)));
         @(negedge clk);
      end

      // narrow instance
      op4(4'hF, 4'h1, 1'b0, r5, lat);
      check("w4_lat", 32'(lat), 32'd4);
      check("w4_sum_F_1", 32'(r5), 32'h10);
      @(negedge clk);
      op4(4'hF, 4'hF, 1'b1, r5, lat);
      check("w4_sum_F_F_1", 32'(r5), 32'h1F);
      @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         logic [3:0] ra, rb;
         logic       rc;
         ra = 4'($urandom);
         rb = 4'($urandom);
         rc = 1'($urandom);
         op4(ra, rb, rc, r5, lat);
         check("rand4", 32'(r5), 32'({1'b0, ra} + {1'b0, rb} + 5'(rc)));
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
